tiny_cpu_uart_tx: RTL and testbench

- Byte-serial transmitter for the tiny CPU's output path.
- Accepts 8-bit words from the CPU core over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out LSB-first on one pin as 8N1 asynchronous serial frames.
- Sits between the CPU output register and a dedicated output pin. It is the transmit counterpart of the pin-level input path.

---
 rtl/tiny_cpu_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_tiny_cpu_uart_tx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tiny_cpu_uart_tx.sv
// FIFO-buffered 8N1 serial transmitter between the tiny CPU output register and its pin.
// Define UART_TX_PARITY_EN to add an even-parity bit to every frame (8E1, 11 bit times).
module tiny_cpu_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [2:0]                    dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       sr_q;
  logic             tx_q;
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [7:0]       mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic             par_q;
`endif

  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       bit_done;
  logic [7:0] head;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on registered state, so a full FIFO never cuts through.
  assign fifo_count  = wr_ptr_q - rd_ptr_q;
  assign fifo_empty  = (fifo_count == '0);
  assign in_ready    = (fifo_count != FULL_CNT);
  assign push        = in_valid && in_ready;
  assign bit_done    = (cnt_q == CNT_TC);
  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign pop         = !fifo_empty &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
  assign tx          = tx_q;
  assign busy        = (state_q != S_IDLE) || !fifo_empty;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sr_q     <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            sr_q    <= head;
            cnt_q   <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
`ifdef UART_TX_PARITY_EN
            par_q   <= ^head;
`endif
          end
        end
        S_START: begin
          if (bit_done) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= sr_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              sr_q  <= {1'b0, sr_q[7:1]};
              idx_q <= idx_q + 3'd1;
              tx_q  <= sr_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            cnt_q <= '0;
            // Chain straight into the next start bit so frames stay back-to-back.
            if (pop) begin
              sr_q    <= head;
              tx_q    <= 1'b0;
              state_q <= S_START;
`ifdef UART_TX_PARITY_EN
              par_q   <= ^head;
`endif
            end else begin
              tx_q    <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_cpu_uart_tx.sv
// Bench for tiny_cpu_uart_tx: table-driven single frames, burst, full-FIFO drop and async reset.
module tb_tiny_cpu_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int frames_seen = 0;
  logic [7:0] exp_q[$];
  int gap_q[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  tiny_cpu_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Call just after a rising edge; returns 1 time unit after the next rising edge.
  task automatic drive_cycle(input logic v, input logic [7:0] d);
    logic acc;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    if (acc) exp_q.push_back(d);
    #1;
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input logic p, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && NB == 11) return p;
    return 1'b1;
  endfunction

  // Line monitor: decodes frames from tx and pops the expected queue on each stop bit.
  initial begin : monitor
    int st, cnt, idx, gap;
    logic [7:0] b, e;
    logic ok, pb;
    st = 0; cnt = 0; idx = 0; gap = 0; b = '0; ok = 1'b1; pb = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        st = 0; gap = 0;
      end else begin
        case (st)
          0: begin
            if (tx === 1'b0) begin
              st = 1; cnt = 1; ok = 1'b1; b = '0;
              gap_q.push_back(gap);
              gap = 0;
            end else begin
              gap++;
            end
          end
          1: begin
            if (tx !== 1'b0) ok = 1'b0;
            cnt++;
            if (cnt == CPB) begin st = 2; cnt = 0; idx = 0; end
          end
          2: begin
            if (cnt == 0) b[idx] = tx;
            else if (tx !== b[idx]) ok = 1'b0;
            cnt++;
            if (cnt == CPB) begin
              cnt = 0; idx++;
`ifdef UART_TX_PARITY_EN
              if (idx == 8) st = 3;
`else
              if (idx == 8) st = 4;
`endif
            end
          end
          3: begin
            if (cnt == 0) pb = tx;
            else if (tx !== pb) ok = 1'b0;
            cnt++;
            if (cnt == CPB) begin st = 4; cnt = 0; end
          end
          default: begin
            if (tx !== 1'b1) ok = 1'b0;
            cnt++;
            if (cnt == CPB) begin
              frames_seen++;
              check("frame_shape", ok, 1'b1);
              if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_frame: got %0h want none", b);
              end else begin
                e = exp_q.pop_front();
                check("frame_byte", b, e);
`ifdef UART_TX_PARITY_EN
                check("frame_parity", pb, ^e);
`endif
              end
              st = 0; gap = 0; cnt = 0;
            end
          end
        endcase
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    vec_t vecs[7];
    int base;
    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b0};
    vecs[3] = '{8'h80, 1'b1};
    vecs[4] = '{8'h01, 1'b1};
    vecs[5] = '{8'h07, 1'b1};
    vecs[6] = '{8'h03, 1'b0};

    // Reset and idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, 3'd0);
    check("rst_tx", tx, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_tx", tx, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_ready", in_ready, 1'b1);
      check("idle_count", fifo_count, 3'd0);
    end

    // Table of single frames: bit-centre samples plus busy fall time
    for (int v = 0; v < 7; v++) begin
      @(posedge clk);
      #1;
      drive_cycle(1'b1, vecs[v].data);
      in_valid = 1'b0;
      for (int n = 0; n <= NB*CPB + 1; n++) begin
        @(negedge clk);
        if (n >= 1 && ((n-1) % CPB) == 1 && ((n-1) / CPB) < NB)
          check($sformatf("tbl%0d_bit%0d", v, (n-1)/CPB), tx,
                exp_bit(vecs[v].data, vecs[v].par, (n-1)/CPB));
        if (n == NB*CPB)     check($sformatf("tbl%0d_busy_hi", v), busy, 1'b1);
        if (n == NB*CPB + 1) check($sformatf("tbl%0d_busy_lo", v), busy, 1'b0);
      end
    end

    // Back-to-back burst then full-FIFO drop
    gap_q.delete();
    base = frames_seen;
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 8'h00);
    drive_cycle(1'b1, 8'hFF);
    drive_cycle(1'b1, 8'h55);
    drive_cycle(1'b1, 8'h0F);
    drive_cycle(1'b1, 8'h81);
    check("b2b_accepted", exp_q.size(), 5);
    check("b2b_ready", in_ready, 1'b0);
    check("b2b_count", fifo_count, 3'd4);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 8'h3C);
      check("drop_count", fifo_count, 3'd4);
      check("drop_ready", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 6*NB*CPB; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("b2b_drain", busy, 1'b0);
    check("b2b_frames", frames_seen - base, 5);
    check("b2b_gaps", gap_q.size(), 5);
    for (int i = 1; i < gap_q.size(); i++)
      check($sformatf("b2b_gap%0d", i), gap_q[i], 0);
    check("b2b_queue_empty", exp_q.size(), 0);

    // Asynchronous reset during data bit 3 of the first frame
    @(posedge clk);
    #1;
    drive_cycle(1'b1, 8'h12);
    drive_cycle(1'b1, 8'h34);
    in_valid = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    check("mid_bit3", tx, 1'b0);
    rst = 1'b1;
    #1;
    check("rst_tx_async", tx, 1'b1);
    check("rst_count_async", fifo_count, 3'd0);
    check("rst_busy_async", busy, 1'b0);
    exp_q.delete();
    base = frames_seen;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("post_rst_tx", tx, 1'b1);
      check("post_rst_count", fifo_count, 3'd0);
    end
    check("post_rst_frames", frames_seen - base, 0);

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
